// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM slew block: widths, default timing,
// slew-state encoding and the pulse-length helper.
package servo_pkg;

  localparam int ANGLE_W = 9;
  localparam int CNT_W   = 21;

  localparam int PERIOD_CYC_D  = 2000000;
  localparam int MIN_CYC_D     = 100000;
  localparam int CYC_PER_DEG_D = 278;
  localparam int MAX_DEG_D     = 360;
  localparam int STEP_DEG_D    = 24;
  localparam int INIT_DEG_D    = 0;

  typedef enum logic [1:0] {
    SETTLED   = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } slew_state_t;

  // Full-width product: 360 deg * 278 cyc + 100000 still fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] pulse_cycles(
    input logic [ANGLE_W-1:0] deg,
    input logic [CNT_W-1:0]   min_cyc,
    input logic [CNT_W-1:0]   per_deg
  );
    logic [CNT_W-1:0] deg_w;
    deg_w = CNT_W'(deg);
    return min_cyc + (deg_w * per_deg);
  endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// Frame counter, frame_start strobe and registered PWM compare against a
// pulse length latched once per frame at the boundary cycle.
module pwm_frame_timer
  import servo_pkg::*;
#(
  parameter int               PERIOD_CYC = PERIOD_CYC_D,
  parameter logic [CNT_W-1:0] INIT_PULSE = 21'd100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] pulse_len_nxt,
  output logic             boundary,
  output logic             pwm,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] pulse_len_r;
  logic             enable_r;
  logic             pwm_r;
  logic             frame_start_r;
  logic             boundary_s;

  assign boundary_s  = (cnt_r == LAST_CNT);
  assign boundary    = boundary_s;
  assign pwm         = pwm_r;
  assign frame_start = frame_start_r;

  // Counter, strobe and pulse compare; a new pulse length only lands at the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r         <= 21'd0;
      pulse_len_r   <= INIT_PULSE;
      enable_r      <= 1'b0;
      pwm_r         <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      cnt_r         <= boundary_s ? 21'd0 : (cnt_r + 21'd1);
      frame_start_r <= boundary_s;
      enable_r      <= enable;
      pwm_r         <= enable_r && (cnt_r < pulse_len_r);
      if (boundary_s) begin
        pulse_len_r <= pulse_len_nxt;
      end
    end
  end

endmodule

// File: rtl/servo_pwm_slew.sv
// 50 Hz servo PWM driver with per-frame angle slew limiting.
// Optional feature macro: SERVO_SLEW_EN (defined = slew FSM, undefined = jump to target).
module servo_pwm_slew
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC  = PERIOD_CYC_D,
  parameter int MIN_CYC     = MIN_CYC_D,
  parameter int CYC_PER_DEG = CYC_PER_DEG_D,
  parameter int MAX_DEG     = MAX_DEG_D,
  parameter int STEP_DEG    = STEP_DEG_D,
  parameter int INIT_DEG    = INIT_DEG_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               enable,
  output logic               pwm,
  output logic [ANGLE_W-1:0] cur_angle,
  output logic               settled,
  output logic               frame_start
);

  localparam logic [ANGLE_W-1:0] MAX_A   = ANGLE_W'(MAX_DEG);
  localparam logic [ANGLE_W-1:0] STEP_A  = ANGLE_W'(STEP_DEG);
  localparam logic [ANGLE_W-1:0] INIT_A  = ANGLE_W'(INIT_DEG);
  localparam logic [CNT_W-1:0]   MIN_W   = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0]   PER_W   = CNT_W'(CYC_PER_DEG);
  localparam logic [CNT_W-1:0]   INIT_PL = pulse_cycles(INIT_A, MIN_W, PER_W);

  if (STEP_DEG <= 0) begin : g_step_chk
    $error("servo_pwm_slew: STEP_DEG must be a positive number of degrees");
  end

  logic               boundary_s;
  logic [ANGLE_W-1:0] tgt_s;
  logic [ANGLE_W-1:0] cur_r;
  logic [ANGLE_W-1:0] cur_nxt_s;
  logic [CNT_W-1:0]   pulse_nxt_s;

  assign tgt_s       = (angle > MAX_A) ? MAX_A : angle;
  assign cur_angle   = cur_r;
  assign pulse_nxt_s = pulse_cycles(cur_nxt_s, MIN_W, PER_W);

`ifdef SERVO_SLEW_EN
  slew_state_t        state_r;
  slew_state_t        state_nxt_s;
  logic [ANGLE_W-1:0] up_diff_s;
  logic [ANGLE_W-1:0] dn_diff_s;
  logic [ANGLE_W-1:0] up_cur_s;
  logic [ANGLE_W-1:0] dn_cur_s;
  logic               settled_r;

  // Each difference is only consumed on the side where the comparison makes it non-negative.
  always_comb begin
    up_diff_s = tgt_s - cur_r;
    dn_diff_s = cur_r - tgt_s;
    up_cur_s  = cur_r + ((up_diff_s < STEP_A) ? up_diff_s : STEP_A);
    dn_cur_s  = cur_r - ((dn_diff_s < STEP_A) ? dn_diff_s : STEP_A);
  end

  // Slew next-state: step toward the target at the boundary, reversing immediately if it moves.
  always_comb begin
    state_nxt_s = state_r;
    cur_nxt_s   = cur_r;
    if (boundary_s) begin
      case (state_r)
        SETTLED, RAMP_UP, RAMP_DOWN: begin
          if (tgt_s > cur_r) begin
            cur_nxt_s   = up_cur_s;
            state_nxt_s = (up_cur_s == tgt_s) ? SETTLED : RAMP_UP;
          end else if (tgt_s < cur_r) begin
            cur_nxt_s   = dn_cur_s;
            state_nxt_s = (dn_cur_s == tgt_s) ? SETTLED : RAMP_DOWN;
          end else begin
            state_nxt_s = SETTLED;
          end
        end
        default: begin
          state_nxt_s = SETTLED;
          cur_nxt_s   = cur_r;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      cur_nxt_s   = cur_r;
    end
  end

  // Slew state, driven angle and settled flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= SETTLED;
      cur_r     <= INIT_A;
      settled_r <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      cur_r     <= cur_nxt_s;
      settled_r <= (state_nxt_s == SETTLED);
    end
  end

  assign settled = settled_r;
`else
  // Without slew limiting the target is taken as-is at every boundary.
  always_comb begin
    cur_nxt_s = cur_r;
    if (boundary_s) begin
      cur_nxt_s = tgt_s;
    end else begin
      cur_nxt_s = cur_r;
    end
  end

  // Driven angle register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_r <= INIT_A;
    end else begin
      cur_r <= cur_nxt_s;
    end
  end

  assign settled = 1'b1;
`endif

  pwm_frame_timer #(
    .PERIOD_CYC (PERIOD_CYC),
    .INIT_PULSE (INIT_PL)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pulse_len_nxt (pulse_nxt_s),
    .boundary      (boundary_s),
    .pwm           (pwm),
    .frame_start   (frame_start)
  );

endmodule

// File: tb/tb_servo_pwm_slew.sv
// Directed self-checking bench for servo_pwm_slew with a 1000-cycle frame;
// expectations follow SERVO_SLEW_EN when it is defined for the build.
module tb_servo_pwm_slew;

`ifdef SERVO_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] angle;
  logic       enable;
  logic       pwm;
  logic [8:0] cur_angle;
  logic       settled;
  logic       frame_start;

  int checks   = 0;
  int failures = 0;

  servo_pwm_slew #(
    .PERIOD_CYC  (1000),
    .MIN_CYC     (50),
    .CYC_PER_DEG (1),
    .MAX_DEG     (360),
    .STEP_DEG    (24),
    .INIT_DEG    (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .angle       (angle),
    .enable      (enable),
    .pwm         (pwm),
    .cur_angle   (cur_angle),
    .settled     (settled),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance (on negedges) until a frame_start strobe is seen.
  task automatic next_frame(input string tag);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_fs_seen"}, {31'd0, frame_start}, 32'd1);
  endtask

  // Entered on the frame_start negedge; checks the frame and returns on the next strobe.
  task automatic check_frame(input string tag, input int exp_cur, input int exp_set,
                             input int exp_hi, input int chg_at, input int chg_angle,
                             input logic chg_en);
    int hi;
    int n;
    chk({tag, "_cur"}, {23'd0, cur_angle}, exp_cur);
    chk({tag, "_settled"}, {31'd0, settled}, exp_set);
    hi = 0;
    n  = 0;
    do begin
      if (n == chg_at) begin
        angle  = chg_angle[8:0];
        enable = chg_en;
      end
      if (pwm === 1'b1) hi++;
      n++;
      @(negedge clk);
    end while (frame_start !== 1'b1 && n < 3000);
    chk({tag, "_pwm_hi"}, hi, exp_hi);
    chk({tag, "_period"}, n, 32'd1000);
  endtask

  initial begin
    int ec;
    int n;
    reset  = 1'b1;
    angle  = 9'd0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pwm", {31'd0, pwm}, 32'd0);
    chk("rst_cur", {23'd0, cur_angle}, 32'd0);
    chk("rst_settled", {31'd0, settled}, 32'd1);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    reset = 1'b0;

    // Idle at 0 degrees: 50-cycle pulses.
    next_frame("t1");
    for (int f = 0; f < 3; f++)
      check_frame($sformatf("t1_f%0d", f), 0, 1, 50, -1, 0, 1'b1);

    // Step to 120 degrees.
    angle = 9'd120;
    check_frame("t2_f0", 0, 1, 50, -1, 120, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      ec = SLEW ? 24 * k : 120;
      check_frame($sformatf("t2_f%0d", k), ec, (!SLEW || k == 5) ? 1 : 0, 50 + ec, -1, 120, 1'b1);
    end

    // Out-of-range request clamps to 360.
    angle = 9'd500;
    check_frame("t3_f0", 120, 1, 170, -1, 500, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      ec = SLEW ? 120 + 24 * k : 360;
      check_frame($sformatf("t3_f%0d", k), ec, (!SLEW || k == 10) ? 1 : 0, 50 + ec, -1, 500, 1'b1);
    end

    // Target drops below the ramp mid-frame: pulse in progress untouched, no overshoot.
    reset = 1'b1;
    angle = 9'd120;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    next_frame("t4");
    check_frame("t4_f0", SLEW ? 24 : 120, SLEW ? 0 : 1, SLEW ? 74 : 170, -1, 120, 1'b1);
    check_frame("t4_f1", SLEW ? 48 : 120, SLEW ? 0 : 1, SLEW ? 98 : 170, -1, 120, 1'b1);
    check_frame("t4_f2", SLEW ? 72 : 120, SLEW ? 0 : 1, SLEW ? 122 : 170, 30, 48, 1'b1);
    check_frame("t4_f3", 48, 1, 98, -1, 48, 1'b1);

    // One disabled frame while a ramp continues underneath.
    check_frame("t5_f0", 48, 1, 98, 999, 96, 1'b0);
    check_frame("t5_f1", SLEW ? 72 : 96, SLEW ? 0 : 1, 0, 999, 96, 1'b1);
    check_frame("t5_f2", 96, 1, 146, -1, 96, 1'b1);

    // Reset asserted 60 cycles into a 170-cycle pulse.
    angle = 9'd120;
    check_frame("t6_f0", 96, 1, 146, -1, 120, 1'b1);
    chk("t6_cur", {23'd0, cur_angle}, 32'd120);
    repeat (60) @(negedge clk);
    chk("t6_pwm_pre", {31'd0, pwm}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_pwm_post", {31'd0, pwm}, 32'd0);
    chk("t6_cur_post", {23'd0, cur_angle}, 32'd0);
    chk("t6_settled_post", {31'd0, settled}, 32'd1);
    chk("t6_fs_post", {31'd0, frame_start}, 32'd0);
    angle = 9'd0;
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 3000);
    chk("t6_restart_len", n, 32'd1000);
    check_frame("t6_f1", 0, 1, 50, -1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_slew.md
Name: servo_pwm_slew

Overview:
- Consumes the 9-bit degree angle produced by the switch-to-angle decoder.
- Drives the valve servo with a standard 50 Hz PWM signal.
- Slew-limits the commanded angle frame by frame, so a switch change never slams the valve.
- Reports the current angle and a settled flag to the display/status logic.

Parameters:
- PERIOD_CYC, 2000000, clk cycles per PWM frame (20 ms at 100 MHz).
- MIN_CYC, 100000, pulse width at 0 degrees (1 ms).
- CYC_PER_DEG, 278, additional pulse cycles per degree.
- MAX_DEG, 360, angle ceiling; larger inputs are clamped.
- STEP_DEG, 24, maximum angle change per frame (slew limit).
- INIT_DEG, 0, angle loaded at reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- angle  in  9  target angle in degrees, level input, may change on any cycle
- enable  in  1  1 = drive pulses; 0 = pwm held low, frame timing keeps running
- pwm  out  1  servo control output
- cur_angle  out  9  angle currently being driven
- settled  out  1  high when cur_angle equals clamped target
- frame_start  out  1  one-cycle strobe on the first cycle of each frame

Behaviour:
- Reset (synchronous, active-high): frame counter = 0, pwm = 0, cur_angle = INIT_DEG, frame_start = 0, settled = 1, FSM = SETTLED, pulse length = MIN_CYC + INIT_DEG*CYC_PER_DEG.
- Frame counter: 21 bits, counts 0..PERIOD_CYC-1, then wraps to 0.
- frame_start is registered and high in the cycle where the counter equals 0.
- Boundary cycle (counter == PERIOD_CYC-1):
  - tgt = min(angle, MAX_DEG) is sampled.
  - cur_angle is updated by the slew rule below.
  - Pulse length is latched as MIN_CYC + next_cur*CYC_PER_DEG. Use a multiplier of at least 21 bits, unsigned, no truncation.
  - The latched pulse length is used for the whole following frame. Angle changes in the middle of a frame never alter the pulse in progress.
- pwm output: pwm = enable_r && (counter < pulse_len). Registered, so one cycle of latency relative to the counter. enable is registered once.
- Slew FSM, evaluated only at the boundary cycle:
  - SETTLED: if tgt > cur, go to RAMP_UP; if tgt < cur, go to RAMP_DOWN; in both cases apply the step in the same boundary cycle.
  - RAMP_UP: cur += min(STEP_DEG, tgt-cur). If the result equals tgt, go to SETTLED. If tgt drops below cur, go to RAMP_DOWN.
  - RAMP_DOWN: mirror of RAMP_UP.
  - Computing the difference never underflows; the subtraction direction is chosen by the comparison.
- settled = (FSM == SETTLED) after the boundary update. It is 0 for the whole frame in which cur_angle still differs from tgt.
- Target moves away mid-ramp: the direction reverses at the next boundary, with no overshoot.
- STEP_DEG = 0 is illegal; guard it with an elaboration-time check.
- Reset mid-frame or mid-pulse: pwm drops in the next cycle and a new frame starts from counter 0.

Optional Feature:
- Macro: SERVO_SLEW_EN.
- Defined: slew FSM as specified above.
- Undefined: no FSM. At each boundary cur_angle = tgt, settled is constant 1, and STEP_DEG is unused.

Decomposition:
- Shared package (servo_pkg): ANGLE_W = 9, default timing constants, and the slew-state enum (SETTLED, RAMP_UP, RAMP_DOWN).
- One natural sub-module, pwm_frame_timer: counter, frame_start, and the pwm compare against a latched pulse length.
- The slew FSM and pulse-length arithmetic stay in the top level.

Test Plan:
Sim parameters for all scenarios: PERIOD_CYC = 1000, MIN_CYC = 50, CYC_PER_DEG = 1, STEP_DEG = 24.
1. Reset with angle = 0, run 3 frames -> pwm high exactly 50 cycles per frame, settled = 1, frame_start every 1000 cycles.
2. angle 0 -> 120 step -> cur_angle 24, 48, 72, 96, 120 over 5 consecutive frames; pulse 74 .. 170 cycles; settled rises in the 5th frame.
3. angle = 500 -> clamped; cur ramps to 360; final pulse 410 cycles; settled = 1.
4. Ramping up at cur = 72, angle changed to 48 mid-frame -> current pulse stays 122; next frame cur = 48, settled = 1; no overshoot.
5. enable = 0 for one frame -> pwm low for the whole frame, frame_start timing unchanged, cur_angle still slews.
6. Assert reset at counter 60 during a 170-cycle pulse -> pwm = 0 next cycle, cur_angle = INIT_DEG, counter restarts at 0.
